// File: rtl/wb_initiator.sv
// Wishbone B4 classic bus master.
// Turns a command stream into single writes or single/incrementing-burst
// reads and returns one response per bus beat.
//
// Handshakes: both the command and the response streams use strict
// valid/ready. A transfer happens on the rising edge where valid and ready
// are both high. A source that raises valid holds valid and its payload
// unchanged until that transfer. Ready may rise or fall freely and does not
// depend on the other side's valid in the same cycle.
module wb_initiator #(
  parameter int TIMEOUT = 1024,
  parameter int MAX_LEN = 256
) (
  input  logic        clk48,
  input  logic        reset_n,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_len,
  // response stream
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        rsp_last,
  // wishbone master
  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_dat_w,
  input  logic [31:0] wishbone_dat_r,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic        wishbone_we,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic        wishbone_ack,
  input  logic        wishbone_err,
  // debug view of the FSM state (0=IDLE, 1=BUS, 2=RESP)
  output logic [1:0]  state_dbg
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [LW-1:0]  beats_left;
  logic [TW-1:0]  tmo_cnt;

  // Only linear incrementing bursts are generated.
  assign wishbone_bte = 2'b00;
  assign state_dbg    = state;

  // Single FSM owning every bus and response register.
  always_ff @(posedge clk48) begin
    if (!reset_n) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_dat        <= 32'h0;
      rsp_err        <= 1'b0;
      rsp_timeout    <= 1'b0;
      rsp_last       <= 1'b0;
      wishbone_adr   <= 30'h0;
      wishbone_dat_w <= 32'h0;
      wishbone_sel   <= 4'h0;
      wishbone_cyc   <= 1'b0;
      wishbone_stb   <= 1'b0;
      wishbone_we    <= 1'b0;
      wishbone_cti   <= CTI_CLASSIC;
      beats_left     <= '0;
      tmo_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready      <= 1'b0;
            wishbone_cyc   <= 1'b1;
            wishbone_stb   <= 1'b1;
            wishbone_we    <= cmd_we;
            wishbone_adr   <= cmd_adr;
            wishbone_dat_w <= cmd_dat;
            wishbone_sel   <= cmd_sel;
            // writes are always a single beat whatever cmd_len says
            beats_left     <= cmd_we ? '0 : LW'(cmd_len);
            wishbone_cti   <= (cmd_we || cmd_len == 8'd0) ? CTI_CLASSIC : CTI_INCR;
            tmo_cnt        <= '0;
            state          <= BUS;
          end
        end

        BUS: begin
          if (wishbone_err) begin
            // err wins over a simultaneous ack and ends the command
            wishbone_stb <= 1'b0;
            wishbone_cyc <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_dat      <= 32'h0;
            rsp_err      <= 1'b1;
            rsp_timeout  <= 1'b0;
            rsp_last     <= 1'b1;
            state        <= RESP;
          end else if (wishbone_ack) begin
            wishbone_stb <= 1'b0;
            // keep the cycle open between beats of a healthy burst
            wishbone_cyc <= (beats_left != '0);
            rsp_valid    <= 1'b1;
            rsp_dat      <= wishbone_we ? 32'h0 : wishbone_dat_r;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_last     <= (beats_left == '0);
            state        <= RESP;
          end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            wishbone_stb <= 1'b0;
            wishbone_cyc <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_dat      <= 32'h0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_last     <= 1'b1;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        RESP: begin
          // response registers stay frozen until the consumer takes them
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (beats_left != '0 && !rsp_err && !rsp_timeout) begin
              wishbone_adr <= wishbone_adr + 30'd1;
              wishbone_stb <= 1'b1;
              wishbone_cti <= (beats_left == LW'(1)) ? CTI_END : CTI_INCR;
              beats_left   <= beats_left - LW'(1);
              tmo_cnt      <= '0;
              state        <= BUS;
            end else begin
              wishbone_cyc <= 1'b0;
              cmd_ready    <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: table of single-beat commands,
// then hand-written burst, backpressure, error, timeout and reset sequences.
module tb_wb_initiator;

  localparam int TIMEOUT = 8;

  // clock / reset
  logic clk48 = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk48 = ~clk48;

  // DUT signals
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [29:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic [7:0]  cmd_len;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, rsp_last;
  logic [31:0] rsp_dat;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_dat_w, wishbone_dat_r;
  logic [3:0]  wishbone_sel;
  logic        wishbone_cyc, wishbone_stb, wishbone_we;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;
  logic        wishbone_ack, wishbone_err;
  logic [1:0]  state_dbg;

  wb_initiator #(.TIMEOUT(TIMEOUT), .MAX_LEN(256)) dut (
    .clk48(clk48), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_last(rsp_last),
    .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w),
    .wishbone_dat_r(wishbone_dat_r), .wishbone_sel(wishbone_sel),
    .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
    .wishbone_we(wishbone_we), .wishbone_cti(wishbone_cti),
    .wishbone_bte(wishbone_bte), .wishbone_ack(wishbone_ack),
    .wishbone_err(wishbone_err), .state_dbg(state_dbg)
  );

  // counters and check helper
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // slave model: acks after slv_delay stb cycles, data = adr ^ 0x55AA
  int   slv_delay = 0;
  int   slv_err_beat = -1;
  bit   slv_silent = 1'b0;
  int   slv_beat = 0;
  int   slv_wait = 0;
  logic slv_ack = 1'b0;
  logic late_ack = 1'b0;
  assign wishbone_ack = slv_ack | late_ack;

  logic [29:0] mon_adr_q[$];
  logic [2:0]  mon_cti_q[$];
  logic        mon_we_q[$];
  logic [31:0] mon_datw_q[$];
  logic [3:0]  mon_sel_q[$];

  always @(negedge clk48) begin
    slv_ack = 1'b0;
    wishbone_err = 1'b0;
    wishbone_dat_r = 32'h0;
    if (wishbone_cyc && wishbone_stb && !slv_silent) begin
      if (slv_wait >= slv_delay) begin
        slv_wait = 0;
        if (slv_beat == slv_err_beat) wishbone_err = 1'b1;
        else begin
          slv_ack = 1'b1;
          wishbone_dat_r = {2'b00, wishbone_adr} ^ 32'h55AA;
        end
        mon_adr_q.push_back(wishbone_adr);
        mon_cti_q.push_back(wishbone_cti);
        mon_we_q.push_back(wishbone_we);
        mon_datw_q.push_back(wishbone_dat_w);
        mon_sel_q.push_back(wishbone_sel);
        slv_beat++;
      end else begin
        slv_wait++;
      end
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic        got_last_q[$];
  logic        got_err_q[$];
  logic        got_tmo_q[$];
  int          stb_cycles;
  int          cyc_gaps;

  task automatic clear_all();
    mon_adr_q.delete(); mon_cti_q.delete(); mon_we_q.delete();
    mon_datw_q.delete(); mon_sel_q.delete();
    exp_q.delete(); got_last_q.delete(); got_err_q.delete(); got_tmo_q.delete();
    slv_beat = 0;
    slv_wait = 0;
  endtask

  // driver: present a command and return on the negedge after acceptance
  task automatic send_cmd(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [7:0] len);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_len = len;
    while (!cmd_ready && n < 50) begin
      @(negedge clk48);
      n++;
    end
    if (!cmd_ready) expire("cmd_accept");
    @(negedge clk48);
    cmd_valid = 1'b0;
  endtask

  // collect responses with rsp_ready high until rsp_last
  task automatic collect(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    stb_cycles = 0;
    cyc_gaps = 0;
    rsp_ready = 1'b1;
    while (!done && n < budget) begin
      if (wishbone_stb) stb_cycles++;
      if (!wishbone_cyc && !(rsp_valid && rsp_last)) cyc_gaps++;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %h expected none", rsp_dat);
        end else begin
          check("rsp_dat", rsp_dat, exp_q.pop_front());
        end
        got_last_q.push_back(rsp_last);
        got_err_q.push_back(rsp_err);
        got_tmo_q.push_back(rsp_timeout);
        done = rsp_last;
      end
      @(negedge clk48);
      n++;
    end
    if (!done) expire("collect");
  endtask

  // single-beat vector table
  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [7:0]  len;
    int          delay;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    logic [31:0] held;

    vecs[0] = '{1'b1, 30'h10,       32'hDEADBEEF, 4'hF, 8'd0, 2, 32'h0,        3};
    vecs[1] = '{1'b0, 30'h20,       32'h0,        4'hF, 8'd0, 0, 32'h0000558A, 1};
    vecs[2] = '{1'b1, 30'h3FFFFFFF, 32'h12345678, 4'h5, 8'd0, 1, 32'h0,        2};
    vecs[3] = '{1'b0, 30'h3FFFFFFF, 32'h0,        4'hF, 8'd0, 3, 32'h3FFFAA55, 4};
    vecs[4] = '{1'b0, 30'h1234,     32'h0,        4'h3, 8'd0, 1, 32'h0000479E, 2};
    vecs[5] = '{1'b1, 30'h40,       32'hA5A5A5A5, 4'h3, 8'd5, 0, 32'h0,        1};

    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_len = '0;
    rsp_ready = 1'b0;

    // reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk48);
    check("rst_cyc", wishbone_cyc, 1'b0);
    check("rst_stb", wishbone_stb, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_adr", wishbone_adr, 30'h0);
    check("rst_cti", wishbone_cti, 3'b000);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_state", state_dbg, 2'd0);
    reset_n = 1'b1;
    @(negedge clk48);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // table of single beats
    foreach (vecs[i]) begin
      clear_all();
      slv_delay = vecs[i].delay;
      exp_q.push_back(vecs[i].exp_dat);
      send_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].len);
      check("vec_stb_after_accept", wishbone_stb, 1'b1);
      collect(50);
      check("vec_stb_cycles", stb_cycles, vecs[i].exp_stb);
      check("vec_nrsp", got_last_q.size(), 1);
      if (got_last_q.size() > 0) begin
        check("vec_last", got_last_q[0], 1'b1);
        check("vec_err", got_err_q[0], 1'b0);
        check("vec_tmo", got_tmo_q[0], 1'b0);
      end
      check("vec_nbeats", mon_adr_q.size(), 1);
      if (mon_adr_q.size() > 0) begin
        check("vec_adr", mon_adr_q[0], vecs[i].adr);
        check("vec_we", mon_we_q[0], vecs[i].we);
        check("vec_sel", mon_sel_q[0], vecs[i].sel);
        check("vec_cti", mon_cti_q[0], 3'b000);
        if (vecs[i].we) check("vec_dat_w", mon_datw_q[0], vecs[i].dat);
      end
      check("vec_cyc_drop", wishbone_cyc, 1'b0);
    end

    // burst read len=3 at 0x100
    clear_all();
    slv_delay = 0;
    exp_q.push_back(32'h54AA); exp_q.push_back(32'h54AB);
    exp_q.push_back(32'h54A8); exp_q.push_back(32'h54A9);
    send_cmd(1'b0, 30'h100, 32'h0, 4'hF, 8'd3);
    collect(100);
    check("burst_nrsp", got_last_q.size(), 4);
    check("burst_cyc_gaps", cyc_gaps, 0);
    check("burst_nbeats", mon_adr_q.size(), 4);
    if (got_last_q.size() == 4 && mon_adr_q.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        check("burst_adr", mon_adr_q[b], 30'h100 + 30'(b));
        check("burst_cti", mon_cti_q[b], (b == 3) ? 3'b111 : 3'b010);
        check("burst_last", got_last_q[b], (b == 3) ? 1'b1 : 1'b0);
      end
    end

    // backpressure: len=1, rsp_ready low for 5 cycles after beat 0
    clear_all();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 30'h200, 32'h0, 4'hF, 8'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk48);
      n++;
    end
    if (!rsp_valid) expire("bp_first_rsp");
    held = rsp_dat;
    check("bp_rsp_dat", held, 32'h57AA);
    for (int c = 0; c < 5; c++) begin
      check("bp_stb_low", wishbone_stb, 1'b0);
      check("bp_cyc_high", wishbone_cyc, 1'b1);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_hold", rsp_dat, 32'h57AA);
      check("bp_last_low", rsp_last, 1'b0);
      @(negedge clk48);
    end
    rsp_ready = 1'b1;
    @(negedge clk48);
    check("bp_stb_resume", wishbone_stb, 1'b1);
    exp_q.push_back(32'h57AB);
    collect(20);
    check("bp_last", (got_last_q.size() == 1) ? got_last_q[0] : 1'b0, 1'b1);
    check("bp_nbeats", mon_cti_q.size(), 2);
    if (mon_cti_q.size() == 2) check("bp_cti_end", mon_cti_q[1], 3'b111);

    // slave err on beat 1 of a len=3 read
    clear_all();
    slv_err_beat = 1;
    exp_q.push_back(32'h56AA); exp_q.push_back(32'h0);
    send_cmd(1'b0, 30'h300, 32'h0, 4'hF, 8'd3);
    collect(50);
    slv_err_beat = -1;
    check("err_nrsp", got_last_q.size(), 2);
    if (got_last_q.size() == 2) begin
      check("err_b0_err", got_err_q[0], 1'b0);
      check("err_b0_last", got_last_q[0], 1'b0);
      check("err_b1_err", got_err_q[1], 1'b1);
      check("err_b1_last", got_last_q[1], 1'b1);
    end
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (wishbone_stb) n++;
      @(negedge clk48);
    end
    check("err_no_stb", n, 0);
    check("err_cyc_low", wishbone_cyc, 1'b0);
    check("err_nbeats", mon_adr_q.size(), 2);
    clear_all();
    exp_q.push_back(32'h55AF);
    send_cmd(1'b0, 30'h5, 32'h0, 4'hF, 8'd0);
    collect(20);
    check("err_next_nrsp", got_last_q.size(), 1);

    // timeout with a silent slave, then a late ack
    clear_all();
    slv_silent = 1'b1;
    exp_q.push_back(32'h0);
    send_cmd(1'b0, 30'h400, 32'h0, 4'hF, 8'd2);
    collect(50);
    check("tmo_stb_cycles", stb_cycles, TIMEOUT);
    check("tmo_nrsp", got_tmo_q.size(), 1);
    if (got_tmo_q.size() == 1) begin
      check("tmo_flag", got_tmo_q[0], 1'b1);
      check("tmo_last", got_last_q[0], 1'b1);
      check("tmo_err", got_err_q[0], 1'b0);
    end
    late_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk48);
      check("late_ack_rsp_valid", rsp_valid, 1'b0);
      check("late_ack_stb", wishbone_stb, 1'b0);
      check("late_ack_cmd_ready", cmd_ready, 1'b1);
    end
    late_ack = 1'b0;
    slv_silent = 1'b0;

    // reset mid-burst
    clear_all();
    slv_delay = 3;
    rsp_ready = 1'b1;
    send_cmd(1'b0, 30'h500, 32'h0, 4'hF, 8'd7);
    n = 0;
    while (mon_adr_q.size() < 2 && n < 100) begin
      @(negedge clk48);
      n++;
    end
    if (mon_adr_q.size() < 2) expire("rst_mid_wait");
    @(negedge clk48);
    reset_n = 1'b0;
    @(negedge clk48);
    check("rst_mid_cyc", wishbone_cyc, 1'b0);
    check("rst_mid_stb", wishbone_stb, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk48);
    reset_n = 1'b1;
    slv_delay = 0;
    clear_all();
    @(negedge clk48);
    check("rst_rel_cmd_ready", cmd_ready, 1'b1);
    check("rst_rel_rsp_valid", rsp_valid, 1'b0);
    exp_q.push_back(32'h53AA); exp_q.push_back(32'h53AB);
    send_cmd(1'b0, 30'h600, 32'h0, 4'hF, 8'd1);
    collect(50);
    check("rst_fresh_nrsp", got_last_q.size(), 2);
    check("rst_fresh_exp_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone B4 classic bus master, the initiator counterpart to the SoC's Wishbone slave port.
- Turns a valid/ready command stream into Wishbone cycles: single writes, or single/incrementing-burst reads. Each beat's result comes back on a valid/ready response stream.
- Used by the EC-side bridge and by simulation harnesses to drive the gateware's Wishbone slave port.

Parameters:
- TIMEOUT, 1024: cycles stb may stay high without ack/err before the beat is aborted; 0 disables the timeout.
- MAX_LEN, 256: maximum read burst length in beats; cmd_len is 8 bits, encoding 1..256 as len-1.

Ports:
- clk48  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1=write (always single beat), 0=read
- cmd_adr  in  30  word address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- cmd_len  in  8  read beats minus 1; ignored for writes
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  response accepted when rsp_valid & rsp_ready
- rsp_dat  out  32  read data; 0 for writes
- rsp_err  out  1  slave asserted err
- rsp_timeout  out  1  beat aborted by timeout
- rsp_last  out  1  final beat of the command
- wishbone_adr  out  30  bus address
- wishbone_dat_w  out  32  bus write data
- wishbone_dat_r  in  32  bus read data
- wishbone_sel  out  4  byte selects
- wishbone_cyc  out  1  cycle
- wishbone_stb  out  1  strobe
- wishbone_we  out  1  write enable
- wishbone_cti  out  3  cycle type
- wishbone_bte  out  2  burst type, constant 00 (linear)
- wishbone_ack  in  1  acknowledge
- wishbone_err  in  1  error

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE.
  - cyc, stb, we, rsp_valid, rsp_err, rsp_timeout, rsp_last = 0.
  - adr, dat_w, sel, cti, rsp_dat = 0.
  - cmd_ready = 0 during reset.
  - Reset mid-cycle drops cyc/stb on the next edge; any pending response is discarded.
- IDLE:
  - cmd_ready=1.
  - On accept: latch the command and set beats_left=cmd_len (writes force 0).
  - Next cycle: cyc=stb=1, we=cmd_we, adr/dat_w/sel driven from the latched command. Go to BUS. Latency from command accept to stb is 1 cycle.
- BUS: stb=1; the timeout counter increments each cycle.
  - ack sampled: capture dat_r (read) or 0 (write); rsp_err=0, rsp_timeout=0. Next cycle stb=0 and the state is RESP.
  - err sampled: same transition with rsp_err=1. err takes precedence if ack and err are both high.
  - Counter reaches TIMEOUT-1 with no ack/err: rsp_timeout=1, rsp_dat=0, go to RESP.
  - Error or timeout terminates the command. rsp_last=1 and the remaining beats are not issued.
  - The counter clears on entry to BUS.
- RESP: rsp_valid=1; stb=0.
  - cyc stays 1 if more beats remain and the beat completed OK; otherwise cyc=0.
  - rsp_valid & rsp_ready with beats_left>0 and no error: adr<=adr+1 (30-bit wrap from 3FFFFFFF to 0 is allowed), beats_left--, stb=1, back to BUS.
  - rsp_valid & rsp_ready otherwise: go to IDLE. cmd_ready reasserts in the cycle after.
  - Response outputs hold stable while rsp_valid & !rsp_ready.
- cti:
  - 000 for a single beat (len 0 or write).
  - 010 for burst beats other than the last.
  - 111 on the last burst beat.
  - cti is only meaningful while stb=1.
- rsp_last=1 on the last beat and on any error/timeout beat.
- Only one command is in flight; cmd_ready=0 outside IDLE.
- ack/err arriving while stb=0 are ignored.

Test Plan:
- Single write: cmd we=1, adr=0x10, dat=0xDEADBEEF, sel=F; ack after 2 cycles -> one cycle with stb=1, we=1, cti=000, dat_w=DEADBEEF; response rsp_dat=0, last=1, err=0; cyc drops.
- Burst read: len=3 at adr=0x100, slave returns adr^0x55AA, rsp_ready tied 1 -> 4 responses with adr 0x100..0x103, cti 010,010,010,111, last only on the 4th, cyc continuous across all beats.
- Backpressure: burst len=1 with rsp_ready=0 for 5 cycles after beat 0 -> stb=0, cyc=1, response held stable; beat 1 issues 1 cycle after rsp_ready rises.
- Slave err on beat 1 of a len=3 read -> rsp_err=1, rsp_last=1, no further stb, cyc=0, next command accepted.
- Timeout with TIMEOUT=8 and a silent slave -> stb high exactly 8 cycles, rsp_timeout=1, rsp_dat=0; a late ack afterwards is ignored.
- reset_n low mid-burst -> next edge cyc=stb=rsp_valid=0, cmd_ready=0; after release cmd_ready=1 and a fresh read completes normally.
